sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 24 ++
 rtl/sipo_deser_if.sv | 38 +++
 rtl/sipo_shreg.sv | 63 ++++++
 rtl/sipo_deser.sv | 109 ++++++++++
 tb/tb_sipo_deser.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, defaults and sizing helpers for the SIPO deserializer
// Contents: state_e (IDLE/SHIFT), DATA_W_DEF, PAR_BITS, cnt_w()
// Honours SIPO_DESER_PARITY_EN: adds one even-parity bit to each serial frame.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;

`ifdef SIPO_DESER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Counter width able to index every bit of a frame; never narrower than 1.
    function automatic int cnt_w(input int frame_w);
        return (frame_w <= 2) ? 1 : $clog2(frame_w);
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// rtl/sipo_deser_if.sv - serial-in / parallel-out handshake bundle
// Signals: si, en, clr (serial side), dout, dvalid, dready (word handshake), ovf,
//          perr (only with SIPO_DESER_PARITY_EN)
// master: upstream serial source plus downstream consumer; slave: the deserializer.
interface sipo_deser_if #(
    parameter int DATA_W = 8
);
    logic              si;
    logic              en;
    logic              clr;
    logic [DATA_W-1:0] dout;
    logic              dvalid;
    logic              dready;
    logic              ovf;
`ifdef SIPO_DESER_PARITY_EN
    logic              perr;

    modport master (
        output si, en, clr, dready,
        input  dout, dvalid, ovf, perr
    );

    modport slave (
        input  si, en, clr, dready,
        output dout, dvalid, ovf, perr
    );
`else
    modport master (
        output si, en, clr, dready,
        input  dout, dvalid, ovf
    );

    modport slave (
        input  si, en, clr, dready,
        output dout, dvalid, ovf
    );
`endif
endinterface

// File: rtl/sipo_shreg.sv
// rtl/sipo_shreg.sv - MSB-first shift register with frame bit counter and done strobe
// Ports: clk, rst (async active-low), en_i (bit valid), si_i (serial bit),
//        clr_i (abort partial frame), sh_o (frame contents), last_o (next bit
//        completes the frame), done_o (one-cycle strobe after a frame completes)
import sipo_pkg::*;

module sipo_shreg #(
    parameter int FRAME_W = 8,
    parameter int CNT_W   = cnt_w(FRAME_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               si_i,
    input  logic               clr_i,
    output logic [FRAME_W-1:0] sh_o,
    output logic               last_o,
    output logic               done_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    assign last_o = (cnt_q == LAST_IDX);
    assign sh_o   = sh_q;
    assign done_o = done_q;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr_i) begin
            // Abort wins over a bit arriving in the same cycle.
            sh_d  = '0;
            cnt_d = '0;
        end else if (en_i) begin
            sh_d = {sh_q[FRAME_W-2:0], si_i};
            if (last_o) begin
                // Wrap straight to 0 so the next frame can start on the following cycle.
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-to-parallel deserializer with valid/ready output word
// Ports: clk, rst (async active-low), bus (sipo_deser_if.slave: si, en, clr,
//        dout, dvalid, dready, ovf, perr)
// Honours SIPO_DESER_PARITY_EN: frame = DATA_W data bits + even-parity bit, perr output.
import sipo_pkg::*;

module sipo_deser #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sipo_deser_if.slave  bus
);

    localparam int FRAME_W = DATA_W + PAR_BITS;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dvalid_q, dvalid_d;
    logic               ovf_q, ovf_d;
    logic               perr_q, perr_d;

    logic [FRAME_W-1:0] frame;
    logic               last_bit;
    logic               done;
    logic               load;
    logic               drop;
    logic               frame_perr;

    sipo_shreg #(
        .FRAME_W (FRAME_W)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.en),
        .si_i   (bus.si),
        .clr_i  (bus.clr),
        .sh_o   (frame),
        .last_o (last_bit),
        .done_o (done)
    );

`ifdef SIPO_DESER_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to 0.
    assign frame_perr = ^frame;
`else
    assign frame_perr = 1'b0;
`endif

    // A finished frame is taken when the holding register is free or being
    // emptied this cycle; otherwise it is lost and flagged. clr freezes the
    // output side for its cycle.
    assign load = done && !bus.clr && (!dvalid_q || bus.dready);
    assign drop = done && !bus.clr && dvalid_q && !bus.dready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en) state_d = SHIFT;
            SHIFT:   if (bus.en && last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.clr) state_d = IDLE;
    end

    always_comb begin
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        perr_d   = perr_q;
        ovf_d    = ovf_q | drop;
        if (bus.clr) begin
            ovf_d = 1'b0;
        end else if (load) begin
            dout_d   = frame[FRAME_W-1 -: DATA_W];
            perr_d   = frame_perr;
            dvalid_d = 1'b1;
        end else if (dvalid_q && bus.dready) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.ovf    = ovf_q;
`ifdef SIPO_DESER_PARITY_EN
    assign bus.perr   = perr_q;
`else
    // perr is only meaningful with parity frames; keep the register tied off.
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed self-checking bench for sipo_deser
import sipo_pkg::*;

module tb_sipo_deser;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    sipo_deser_if #(.DATA_W(8)) bus ();

    sipo_deser #(
        .DATA_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.en = 1'b1;
        bus.si = b;
        tick();
        bus.en = 1'b0;
        bus.si = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
`ifdef SIPO_DESER_PARITY_EN
        send_bit(^b);
`endif
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst        = 1'b0;
        bus.si     = 1'b0;
        bus.en     = 1'b0;
        bus.clr    = 1'b0;
        bus.dready = 1'b0;
        tick();
        tick();
        check("rst_dout",   32'(bus.dout),   32'h00);
        check("rst_dvalid", 32'(bus.dvalid), 32'h0);
        check("rst_ovf",    32'(bus.ovf),    32'h0);
        rst = 1'b1;
        tick();

        // A5 with consumer always ready
        bus.dready = 1'b1;
        send_byte(8'hA5);
        check("a5_not_yet", 32'(bus.dvalid), 32'h0);
        tick();
        check("a5_dvalid", 32'(bus.dvalid), 32'h1);
        check("a5_dout",   32'(bus.dout),   32'hA5);
        tick();
        check("a5_consumed", 32'(bus.dvalid), 32'h0);
        check("a5_hold",     32'(bus.dout),   32'hA5);

        // 3C then C3 back-to-back, consumer stalled
        bus.dready = 1'b0;
        send_byte(8'h3C);
        send_byte(8'hC3);
        check("ovf_pre", 32'(bus.ovf), 32'h0);
        tick();
        check("ovf_set",    32'(bus.ovf),    32'h1);
        check("ovf_dout",   32'(bus.dout),   32'h3C);
        check("ovf_dvalid", 32'(bus.dvalid), 32'h1);
        tick();
        check("ovf_sticky", 32'(bus.ovf), 32'h1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_ovf",    32'(bus.ovf),    32'h0);
        check("clr_dvalid", 32'(bus.dvalid), 32'h1);
        check("clr_dout",   32'(bus.dout),   32'h3C);
        bus.dready = 1'b1;
        tick();
        check("drain", 32'(bus.dvalid), 32'h0);

        // Partial word aborted by clr (with a bit offered in the clr cycle)
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        bus.clr = 1'b1;
        send_bit(1'b1);
        bus.clr = 1'b0;
        send_byte(8'hFF);
        check("ff_not_yet", 32'(bus.dvalid), 32'h0);
        tick();
        check("ff_dvalid", 32'(bus.dvalid), 32'h1);
        check("ff_dout",   32'(bus.dout),   32'hFF);
        tick();

        // Reset mid-word with a word held in the output register
        bus.dready = 1'b0;
        send_byte(8'h77);
        tick();
        check("pre_rst_dvalid", 32'(bus.dvalid), 32'h1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst = 1'b0;
        #2;
        check("in_rst_dvalid", 32'(bus.dvalid), 32'h0);
        check("in_rst_dout",   32'(bus.dout),   32'h00);
        tick();
        tick();
        check("in_rst_dvalid2", 32'(bus.dvalid), 32'h0);
        rst = 1'b1;
        send_byte(8'h81);
        tick();
        check("81_dvalid", 32'(bus.dvalid), 32'h1);
        check("81_dout",   32'(bus.dout),   32'h81);
        check("81_ovf",    32'(bus.ovf),    32'h0);
        bus.dready = 1'b1;
        tick();
        bus.dready = 1'b0;
        check("81_drain", 32'(bus.dvalid), 32'h0);

        // Second word completes in the cycle the first is consumed
        send_byte(8'h5A);
        send_byte(8'h96);
        check("sim_first", 32'(bus.dout), 32'h5A);
        bus.dready = 1'b1;
        tick();
        bus.dready = 1'b0;
        check("sim_dvalid", 32'(bus.dvalid), 32'h1);
        check("sim_dout",   32'(bus.dout),   32'h96);
        check("sim_ovf",    32'(bus.ovf),    32'h0);
        tick();
        check("sim_hold", 32'(bus.dout), 32'h96);
        bus.dready = 1'b1;
        tick();
        check("sim_drain", 32'(bus.dvalid), 32'h0);

`ifdef SIPO_DESER_PARITY_EN
        // Raw frames: 8'h01 with wrong then correct even parity
        for (int i = 7; i >= 0; i--) send_bit((i == 0) ? 1'b1 : 1'b0);
        send_bit(1'b0);
        tick();
        check("par_bad_dout", 32'(bus.dout), 32'h01);
        check("par_bad_perr", 32'(bus.perr), 32'h1);
        for (int i = 7; i >= 0; i--) send_bit((i == 0) ? 1'b1 : 1'b0);
        send_bit(1'b1);
        tick();
        check("par_ok_dout", 32'(bus.dout), 32'h01);
        check("par_ok_perr", 32'(bus.perr), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
